// File: rtl/unidad_mult_div.sv
// unidad_mult_div: iterative multiply/divide unit that owns the HI/LO pair.
// Handles MULT/MULTU with shift-add and DIV/DIVU with restoring division,
// one bit per cycle. It also takes MTHI/MTLO writes while idle.
module unidad_mult_div #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [1:0]       operacion,
  input  logic [ANCHO-1:0] operandoA,
  input  logic [ANCHO-1:0] operandoB,
  input  logic             escribir_hi,
  input  logic             escribir_lo,
  input  logic [ANCHO-1:0] dato_escritura,
  output logic [ANCHO-1:0] hi,
  output logic [ANCHO-1:0] lo,
  output logic             ocupado,
  output logic             listo,
  output logic             div_cero
);

  localparam int CW = $clog2(ANCHO);

  typedef enum logic [1:0] {REPOSO, CALCULO, AJUSTE} estado_t;

  estado_t              estado;
  logic                 es_div;
  logic                 signo_a;
  logic                 signo_b;
  logic [ANCHO-1:0]     mag_a;
  logic [ANCHO-1:0]     mag_b;
  logic                 cargar;
  logic [CW-1:0]        cnt;
  // Low half holds multiplier / quotient; high half holds the running product.
  logic [2*ANCHO-1:0]   acc;
  // Committed remainder. The ANCHO+1-bit partial remainder is 'desplazado'.
  logic [ANCHO-1:0]     rem;

  logic                 con_signo;
  logic                 signo_a_in;
  logic                 signo_b_in;
  logic [ANCHO-1:0]     mag_a_in;
  logic [ANCHO-1:0]     mag_b_in;
  logic [ANCHO:0]       desplazado;
  logic [ANCHO:0]       resta;
  logic [ANCHO:0]       suma;
  logic [2*ANCHO-1:0]   prod_aj;
  logic [ANCHO-1:0]     coc_aj;
  logic [ANCHO-1:0]     rem_aj;

  // Operand magnitudes, one iteration step of each algorithm, and the final sign fix-up.
  // A zero divisor keeps the all-ones quotient unsigned so that LO reads all ones even for a negative dividend.
  always_comb begin
    con_signo  = ~operacion[0];
    signo_a_in = con_signo & operandoA[ANCHO-1];
    signo_b_in = con_signo & operandoB[ANCHO-1];
    mag_a_in   = signo_a_in ? -operandoA : operandoA;
    mag_b_in   = signo_b_in ? -operandoB : operandoB;
    desplazado = {rem, acc[ANCHO-1]};
    resta      = desplazado - {1'b0, mag_b};
    suma       = {1'b0, acc[2*ANCHO-1:ANCHO]} + {1'b0, mag_b};
    prod_aj    = (signo_a ^ signo_b) ? -acc : acc;
    coc_aj     = ((signo_a ^ signo_b) & ~div_cero) ? -acc[ANCHO-1:0] : acc[ANCHO-1:0];
    rem_aj     = signo_a ? -rem : rem;
  end

  // Control FSM plus datapath registers. CALCULO spends one load cycle, then runs ANCHO iterations.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado   <= REPOSO;
      hi       <= '0;
      lo       <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      div_cero <= 1'b0;
      es_div   <= 1'b0;
      signo_a  <= 1'b0;
      signo_b  <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      cargar   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      listo <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            es_div   <= operacion[1];
            signo_a  <= signo_a_in;
            signo_b  <= signo_b_in;
            mag_a    <= mag_a_in;
            mag_b    <= mag_b_in;
            div_cero <= operacion[1] && (operandoB == '0);
            cargar   <= 1'b1;
            ocupado  <= 1'b1;
            estado   <= CALCULO;
          end else begin
            if (escribir_hi) hi <= dato_escritura;
            if (escribir_lo) lo <= dato_escritura;
          end
        end
        CALCULO: begin
          if (cargar) begin
            acc    <= {{ANCHO{1'b0}}, mag_a};
            rem    <= '0;
            cnt    <= CW'(ANCHO - 1);
            cargar <= 1'b0;
          end else begin
            if (es_div) begin
              if (!resta[ANCHO]) begin
                rem              <= resta[ANCHO-1:0];
                acc[ANCHO-1:0]   <= {acc[ANCHO-2:0], 1'b1};
              end else begin
                rem              <= desplazado[ANCHO-1:0];
                acc[ANCHO-1:0]   <= {acc[ANCHO-2:0], 1'b0};
              end
            end else begin
              acc <= acc[0] ? {suma, acc[ANCHO-1:1]} : {1'b0, acc[2*ANCHO-1:1]};
            end
            if (cnt == '0) estado <= AJUSTE;
            else           cnt    <= cnt - 1'b1;
          end
        end
        AJUSTE: begin
          if (es_div) begin
            lo <= coc_aj;
            hi <= rem_aj;
          end else begin
            hi <= prod_aj[2*ANCHO-1:ANCHO];
            lo <= prod_aj[ANCHO-1:0];
          end
          listo   <= 1'b1;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: begin
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_mult_div.sv
// tb_unidad_mult_div: directed scenarios for the multiply/divide unit.
module tb_unidad_mult_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         inicio;
  logic [1:0]   operacion;
  logic [W-1:0] operandoA;
  logic [W-1:0] operandoB;
  logic         escribir_hi;
  logic         escribir_lo;
  logic [W-1:0] dato_escritura;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         ocupado;
  logic         listo;
  logic         div_cero;

  int errors = 0;
  int checks = 0;

  unidad_mult_div #(.ANCHO(W)) dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .operacion(operacion),
    .operandoA(operandoA), .operandoB(operandoB), .escribir_hi(escribir_hi),
    .escribir_lo(escribir_lo), .dato_escritura(dato_escritura),
    .hi(hi), .lo(lo), .ocupado(ocupado), .listo(listo), .div_cero(div_cero)
  );

  always #5 clk = ~clk;

  // Present one start request for exactly one edge; returns 1ns after the accepting edge.
  task applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    operacion = op; operandoA = a; operandoB = b; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
  endtask

  // Wait (bounded) for listo; reports edges taken and whether hi/lo moved before it.
  task esperarListo(output int n, output logic cambio);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; cambio = 1'b0;
    while (!listo && n < 40) begin
      @(posedge clk); #1; n++;
      if (!listo && (hi !== h0 || lo !== l0)) cambio = 1'b1;
    end
  endtask

  task test_reset;
    reset_n = 1'b0; inicio = 1'b0; operacion = 2'b00; operandoA = '0; operandoB = '0;
    escribir_hi = 1'b0; escribir_lo = 1'b0; dato_escritura = '0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocupado: got %b expected 0", ocupado); end
    checks++; if (listo !== 1'b0) begin errors++; $display("[TB] FAIL reset_listo: got %b expected 0", listo); end
    checks++; if (div_cero !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_cero: got %b expected 0", div_cero); end
  endtask

  task test_mult_signed;
    int n; logic cambio;
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5);
    checks++; if (ocupado !== 1'b1) begin errors++; $display("[TB] FAIL mult_ocupado_start: got %b expected 1", ocupado); end
    esperarListo(n, cambio);
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 34", n); end
    checks++; if (cambio !== 1'b0) begin errors++; $display("[TB] FAIL mult_hilo_hold: got %b expected 0", cambio); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h expected %h", lo, 32'hFFFFFFF1); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL mult_ocupado_end: got %b expected 0", ocupado); end
    checks++; if (div_cero !== 1'b0) begin errors++; $display("[TB] FAIL mult_div_cero: got %b expected 0", div_cero); end
    @(posedge clk); #1;
    checks++; if (listo !== 1'b0) begin errors++; $display("[TB] FAIL mult_listo_pulse: got %b expected 0", listo); end
  endtask

  task test_multu;
    int n; logic cambio;
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    esperarListo(n, cambio);
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 34", n); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, 32'hFFFFFFFE); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, 32'h1); end
    @(posedge clk); #1;
  endtask

  task test_div_signed;
    int n; logic cambio;
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2);
    esperarListo(n, cambio);
    checks++; if (cambio !== 1'b0) begin errors++; $display("[TB] FAIL div_hilo_hold: got %b expected 0", cambio); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    @(posedge clk); #1;
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    esperarListo(n, cambio);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h expected %h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (div_cero !== 1'b0) begin errors++; $display("[TB] FAIL div_ovf_flag: got %b expected 0", div_cero); end
    @(posedge clk); #1;
  endtask

  task test_div_zero;
    int n; logic cambio;
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0);
    esperarListo(n, cambio);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL sdivz_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
    checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("[TB] FAIL sdivz_hi: got %h expected %h", hi, 32'hFFFFFFF9); end
    @(posedge clk); #1;
    applyStimulus(2'b11, 32'd100, 32'd0);
    esperarListo(n, cambio);
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL divz_latency: got %0d expected 34", n); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divz_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
    checks++; if (hi !== 32'h00000064) begin errors++; $display("[TB] FAIL divz_hi: got %h expected %h", hi, 32'h64); end
    checks++; if (div_cero !== 1'b1) begin errors++; $display("[TB] FAIL divz_flag: got %b expected 1", div_cero); end
  endtask

  // Starts in the listo cycle left by test_div_zero.
  task test_back_to_back;
    int n; logic cambio;
    applyStimulus(2'b01, 32'd2, 32'd3);
    checks++; if (div_cero !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flag_cleared: got %b expected 0", div_cero); end
    checks++; if (ocupado !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accepted: got %b expected 1", ocupado); end
    esperarListo(n, cambio);
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", n); end
    checks++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL b2b_lo: got %h expected %h", lo, 32'd6); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL b2b_hi: got %h expected %h", hi, 32'd0); end
    @(posedge clk); #1;
  endtask

  task test_ignored_while_busy;
    int n; logic cambio; logic [W-1:0] h0, l0;
    applyStimulus(2'b00, 32'd7, 32'd9);
    h0 = hi; l0 = lo; n = 0; cambio = 1'b0;
    while (!listo && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 5) begin
        inicio = 1'b1; operacion = 2'b11; operandoA = 32'd1; operandoB = 32'd1;
        escribir_lo = 1'b1; dato_escritura = 32'h0000DEAD;
      end else begin
        inicio = 1'b0; escribir_lo = 1'b0;
      end
      if (!listo && (hi !== h0 || lo !== l0)) cambio = 1'b1;
    end
    inicio = 1'b0; escribir_lo = 1'b0;
    checks++; if (cambio !== 1'b0) begin errors++; $display("[TB] FAIL busy_hilo_hold: got %b expected 0", cambio); end
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 34", n); end
    checks++; if (lo !== 32'd63) begin errors++; $display("[TB] FAIL busy_lo: got %h expected %h", lo, 32'd63); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL busy_hi: got %h expected %h", hi, 32'd0); end
    @(posedge clk); #1;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL busy_not_queued: got %b expected 0", ocupado); end
    escribir_hi = 1'b1; dato_escritura = 32'h00001234;
    @(posedge clk); #1;
    escribir_hi = 1'b0;
    checks++; if (hi !== 32'h00001234) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected %h", hi, 32'h1234); end
    checks++; if (lo !== 32'd63) begin errors++; $display("[TB] FAIL mthi_lo: got %h expected %h", lo, 32'd63); end
  endtask

  task test_start_wins;
    int n; logic cambio;
    escribir_hi = 1'b1; dato_escritura = 32'h0000AAAA;
    applyStimulus(2'b01, 32'd3, 32'd4);
    escribir_hi = 1'b0;
    checks++; if (hi !== 32'h00001234) begin errors++; $display("[TB] FAIL start_wins_hi: got %h expected %h", hi, 32'h1234); end
    esperarListo(n, cambio);
    checks++; if (cambio !== 1'b0) begin errors++; $display("[TB] FAIL start_wins_hold: got %b expected 0", cambio); end
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL start_wins_res_hi: got %h expected %h", hi, 32'd0); end
    checks++; if (lo !== 32'd12) begin errors++; $display("[TB] FAIL start_wins_res_lo: got %h expected %h", lo, 32'd12); end
    @(posedge clk); #1;
  endtask

  task test_abort_reset;
    int n; logic cambio; logic vioListo;
    applyStimulus(2'b11, 32'd100, 32'd0);
    repeat (8) @(posedge clk);
    #1; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL abort_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL abort_lo: got %h expected %h", lo, 32'h0); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL abort_ocupado: got %b expected 0", ocupado); end
    checks++; if (div_cero !== 1'b0) begin errors++; $display("[TB] FAIL abort_div_cero: got %b expected 0", div_cero); end
    vioListo = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (listo !== 1'b0) vioListo = 1'b1;
    end
    checks++; if (vioListo !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_listo: got %b expected 0", vioListo); end
    applyStimulus(2'b11, 32'd10, 32'd3);
    esperarListo(n, cambio);
    checks++; if (n !== 34) begin errors++; $display("[TB] FAIL abort_new_latency: got %0d expected 34", n); end
    checks++; if (lo !== 32'd3) begin errors++; $display("[TB] FAIL abort_new_lo: got %h expected %h", lo, 32'd3); end
    checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL abort_new_hi: got %h expected %h", hi, 32'd1); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset;
    test_mult_signed;
    test_multu;
    test_div_signed;
    test_div_zero;
    test_back_to_back;
    test_ignored_while_busy;
    test_start_wins;
    test_abort_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
